// File: rtl/video_pkg.sv
// Shared video constants, pixel types and the NES palette ROM used by the line buffer
// and the timing generator.
package video_pkg;

    localparam int unsigned LINE_W = 256;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned PTR_W  = $clog2(LINE_W);
    localparam int unsigned RAM_AW = PTR_W + 1;
    localparam int unsigned HPOS_W = 9;
    localparam int unsigned COL_W  = 8;
    localparam int unsigned PAL_N  = 64;

    typedef logic [IDX_W-1:0] pal_idx_t;

    typedef struct packed {
        logic [COL_W-1:0] r;
        logic [COL_W-1:0] g;
        logic [COL_W-1:0] b;
    } rgb_t;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } wr_state_t;

    localparam logic [23:0] NES_PALETTE [PAL_N] = '{
        24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
        24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
        24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
        24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
        24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
        24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
        24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
        24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
    };

    // Grey ramp: index replicated into the top bits so 63 maps to full white.
    function automatic rgb_t grey_rgb(input pal_idx_t idx);
        logic [COL_W-1:0] v;
        v = {idx, idx[IDX_W-1:IDX_W-2]};
        return '{r: v, g: v, b: v};
    endfunction

    function automatic rgb_t palette_rgb(input pal_idx_t idx);
        return rgb_t'(NES_PALETTE[idx]);
    endfunction

endpackage

// File: rtl/video_line_ram.sv
// Two-bank scanline RAM: one write port, one registered read port, address = {bank, ptr}.
module video_line_ram
    import video_pkg::*;
(
    input  logic              I_clock,
    input  logic              wr_en,
    input  logic [RAM_AW-1:0] wr_addr,
    input  pal_idx_t          wr_data,
    input  logic [RAM_AW-1:0] rd_addr,
    output pal_idx_t          rd_data
);

    pal_idx_t mem_q [2*LINE_W];
    pal_idx_t rd_data_q;

    // Storage is deliberately left out of reset so it maps onto a plain RAM macro.
    always_ff @(posedge I_clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/video_line_buffer.sv
// Double-buffered scanline store between pixel generator and video timing stage.
// Define LINEBUF_PALETTE_EN to map indices through the NES palette (latency 2); otherwise grey ramp.
module video_line_buffer
    import video_pkg::*;
(
    input  logic              I_clock,
    input  logic              I_reset,
    input  logic              I_pix_valid,
    input  logic [IDX_W-1:0]  I_pix_index,
    output logic              O_pix_ready,
    input  logic              I_frame_start,
    input  logic              I_rd_active,
    input  logic [HPOS_W-1:0] I_rd_hpos,
    input  logic              I_rd_line_end,
    output logic [COL_W-1:0]  O_red,
    output logic [COL_W-1:0]  O_green,
    output logic [COL_W-1:0]  O_blue,
    output logic              O_underrun
);

    wr_state_t         state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic              wr_bank_q, wr_bank_d;
    logic              pix_ready_q, pix_ready_d;
    logic              underrun_q, underrun_d;
    logic              rd_active_q, rd_active_d;
    logic              wr_fire_c, last_wr_c, swap_c, rd_ok_c;
    pal_idx_t          rd_idx;

    // Frame start wins over a simultaneous pixel, so that pixel is dropped.
    assign wr_fire_c = I_pix_valid && (state_q == FILL) && !I_frame_start;
    assign last_wr_c = wr_fire_c && (wr_ptr_q == PTR_W'(LINE_W - 1));
    assign swap_c    = I_rd_line_end && ((state_q == FULL) || last_wr_c);
    assign rd_ok_c   = I_rd_active && (I_rd_hpos < HPOS_W'(LINE_W));

    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            state_q     <= FILL;
            wr_ptr_q    <= '0;
            wr_bank_q   <= 1'b0;
            pix_ready_q <= 1'b1;
            underrun_q  <= 1'b0;
            rd_active_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_bank_q   <= wr_bank_d;
            pix_ready_q <= pix_ready_d;
            underrun_q  <= underrun_d;
            rd_active_q <= rd_active_d;
        end
    end

    // Next state: pixel write, then line-end swap, then frame-start rewind of the write side.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        wr_bank_d = wr_bank_q;
        if (wr_fire_c) begin
            if (last_wr_c) begin
                state_d = FULL;
            end else begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
        end
        if (swap_c) begin
            wr_bank_d = !wr_bank_q;
            wr_ptr_d  = '0;
            state_d   = FILL;
        end
        if (I_frame_start) begin
            wr_ptr_d = '0;
            state_d  = FILL;
        end
    end

    always_comb begin
        pix_ready_d = 1'b0;
        underrun_d  = 1'b0;
        rd_active_d = rd_ok_c;
        pix_ready_d = (state_d == FILL);
        underrun_d  = I_rd_line_end && !swap_c;
    end

    video_line_ram u_ram (
        .I_clock (I_clock),
        .wr_en   (wr_fire_c),
        .wr_addr ({wr_bank_q, wr_ptr_q}),
        .wr_data (I_pix_index),
        .rd_addr ({!wr_bank_q, I_rd_hpos[PTR_W-1:0]}),
        .rd_data (rd_idx)
    );

`ifdef LINEBUF_PALETTE_EN
    rgb_t rgb_q, rgb_d;

    always_comb begin
        rgb_d = rgb_t'('0);
        if (rd_active_q) begin
            rgb_d = palette_rgb(rd_idx);
        end
    end

    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            rgb_q <= rgb_t'('0);
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign O_red   = rgb_q.r;
    assign O_green = rgb_q.g;
    assign O_blue  = rgb_q.b;
`else
    rgb_t rgb_c;

    // Blank flag travels with the RAM read so masking lines up with the data.
    always_comb begin
        rgb_c = rgb_t'('0);
        if (rd_active_q) begin
            rgb_c = grey_rgb(rd_idx);
        end
    end

    assign O_red   = rgb_c.r;
    assign O_green = rgb_c.g;
    assign O_blue  = rgb_c.b;
`endif

    assign O_pix_ready = pix_ready_q;
    assign O_underrun  = underrun_q;

endmodule

// File: tb/tb_video_line_buffer.sv
// Self-checking bench for video_line_buffer: read-vector table plus scoreboarded line reads
// and hand-written sequences for swap, underrun, frame start and asynchronous reset.
module tb_video_line_buffer;
    import video_pkg::*;

`ifdef LINEBUF_PALETTE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        I_reset;
    logic        I_pix_valid;
    logic [5:0]  I_pix_index;
    logic        O_pix_ready;
    logic        I_frame_start;
    logic        I_rd_active;
    logic [8:0]  I_rd_hpos;
    logic        I_rd_line_end;
    logic [7:0]  O_red, O_green, O_blue;
    logic        O_underrun;

    video_line_buffer dut (
        .I_clock       (clk),
        .I_reset       (I_reset),
        .I_pix_valid   (I_pix_valid),
        .I_pix_index   (I_pix_index),
        .O_pix_ready   (O_pix_ready),
        .I_frame_start (I_frame_start),
        .I_rd_active   (I_rd_active),
        .I_rd_hpos     (I_rd_hpos),
        .I_rd_line_end (I_rd_line_end),
        .O_red         (O_red),
        .O_green       (O_green),
        .O_blue        (O_blue),
        .O_underrun    (O_underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [23:0] exp;
        int          hpos;
    } sb_t;

    typedef struct {
        bit act;
        int hpos;
        int idx;   // -1: blank expected
    } vec_t;

    sb_t  sb_q[$];
    vec_t vt[10];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    function automatic logic [23:0] exp_rgb(input int idx);
        logic [7:0] v;
`ifdef LINEBUF_PALETTE_EN
        v = 8'(0);
        return NES_PALETTE[idx];
`else
        v = 8'((idx * 4) + (idx / 16));
        return {v, v, v};
`endif
    endfunction

    function automatic int pat(input int p, input int i);
        case (p)
            0:       return i % 64;
            1:       return (i + 7) % 64;
            2:       return (i * 3) % 64;
            3:       return 63 - (i % 64);
            4:       return (i + 20) % 64;
            5:       return (i + 1) % 64;
            6:       return (i * 5 + 3) % 64;
            default: return (i * 7 + 2) % 64;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock, sample 1ns after the edge and retire due scoreboard entries.
    task automatic tick();
        sb_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            check($sformatf("rgb hpos=%0d", e.hpos), int'({O_red, O_green, O_blue}), int'(e.exp));
        end
    endtask

    task automatic drive_read(input bit act, input int hpos, input logic [23:0] exp);
        sb_t e;
        I_rd_active = act;
        I_rd_hpos   = 9'(hpos);
        e.due  = cyc + LAT;
        e.exp  = exp;
        e.hpos = hpos;
        sb_q.push_back(e);
        tick();
    endtask

    task automatic idle_read();
        I_rd_active = 1'b0;
        repeat (LAT) tick();
    endtask

    task automatic read_line(input int p);
        for (int h = 0; h < 256; h++) begin
            drive_read(1'b1, h, exp_rgb(pat(p, h)));
        end
        idle_read();
    endtask

    task automatic write_line(input int p, input int from, input int n);
        for (int i = from; i < from + n; i++) begin
            check("ready during fill", int'(O_pix_ready), 1);
            I_pix_valid = 1'b1;
            I_pix_index = 6'(pat(p, i));
            tick();
        end
        I_pix_valid = 1'b0;
    endtask

    task automatic pulse_line_end();
        I_rd_line_end = 1'b1;
        tick();
        I_rd_line_end = 1'b0;
    endtask

    initial begin
        I_reset       = 1'b1;
        I_pix_valid   = 1'b0;
        I_pix_index   = 6'd0;
        I_frame_start = 1'b0;
        I_rd_active   = 1'b0;
        I_rd_hpos     = 9'd0;
        I_rd_line_end = 1'b0;
        #1 I_reset = 1'b0;
        #2;
        check("reset ready", int'(O_pix_ready), 1);
        check("reset rgb", int'({O_red, O_green, O_blue}), 0);
        check("reset underrun", int'(O_underrun), 0);
        repeat (2) @(posedge clk);
        #1 I_reset = 1'b1;

        // Full line, then overflow attempts that must be ignored.
        write_line(0, 0, 256);
        check("full ready", int'(O_pix_ready), 0);
        I_pix_valid = 1'b1;
        I_pix_index = 6'd0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("full hold ready", int'(O_pix_ready), 0);
        end
        I_pix_valid = 1'b0;
        pulse_line_end();
        check("swap underrun", int'(O_underrun), 0);
        check("swap ready", int'(O_pix_ready), 1);

        vt[0] = '{1'b1, 0,   pat(0, 0)};
        vt[1] = '{1'b1, 1,   pat(0, 1)};
        vt[2] = '{1'b1, 63,  pat(0, 63)};
        vt[3] = '{1'b1, 64,  pat(0, 64)};
        vt[4] = '{1'b1, 255, pat(0, 255)};
        vt[5] = '{1'b0, 10,  -1};
        vt[6] = '{1'b1, 256, -1};
        vt[7] = '{1'b1, 300, -1};
        vt[8] = '{1'b1, 511, -1};
        vt[9] = '{1'b1, 130, pat(0, 130)};
        for (int v = 0; v < 10; v++) begin
            drive_read(vt[v].act, vt[v].hpos, (vt[v].idx < 0) ? 24'h0 : exp_rgb(vt[v].idx));
        end
        idle_read();
        read_line(0);

        // Short line: underrun, displayed line repeats, fill continues where it left off.
        write_line(1, 0, 100);
        pulse_line_end();
        check("underrun pulse", int'(O_underrun), 1);
        check("underrun ready", int'(O_pix_ready), 1);
        tick();
        check("underrun one cycle", int'(O_underrun), 0);
        read_line(0);
        write_line(1, 100, 156);
        check("resume full ready", int'(O_pix_ready), 0);
        pulse_line_end();
        check("resume underrun", int'(O_underrun), 0);
        read_line(1);

        // Last write coincides with line end.
        write_line(2, 0, 255);
        check("pre-coincide ready", int'(O_pix_ready), 1);
        I_pix_valid   = 1'b1;
        I_pix_index   = 6'(pat(2, 255));
        I_rd_line_end = 1'b1;
        tick();
        I_pix_valid   = 1'b0;
        I_rd_line_end = 1'b0;
        check("coincide underrun", int'(O_underrun), 0);
        check("coincide ready", int'(O_pix_ready), 1);
        read_line(2);
        write_line(3, 0, 255);
        check("restart 255 ready", int'(O_pix_ready), 1);
        write_line(3, 255, 1);
        check("restart full ready", int'(O_pix_ready), 0);
        pulse_line_end();
        read_line(3);

        // Frame start mid-line: write side rewinds, no swap.
        write_line(4, 0, 50);
        I_frame_start = 1'b1;
        I_pix_valid   = 1'b1;
        I_pix_index   = 6'd9;
        tick();
        I_frame_start = 1'b0;
        I_pix_valid   = 1'b0;
        check("frame start ready", int'(O_pix_ready), 1);
        drive_read(1'b1, 0, exp_rgb(pat(3, 0)));
        drive_read(1'b1, 200, exp_rgb(pat(3, 200)));
        idle_read();
        write_line(5, 0, 255);
        check("fs 255 ready", int'(O_pix_ready), 1);
        write_line(5, 255, 1);
        check("fs full ready", int'(O_pix_ready), 0);
        pulse_line_end();
        check("fs swap underrun", int'(O_underrun), 0);
        read_line(5);

        // Asynchronous reset while FULL and displaying.
        write_line(6, 0, 256);
        check("pre-reset ready", int'(O_pix_ready), 0);
        drive_read(1'b1, 5, exp_rgb(pat(5, 5)));
        repeat (LAT - 1) tick();
        #2 I_reset = 1'b0;
        #1;
        check("async reset ready", int'(O_pix_ready), 1);
        check("async reset rgb", int'({O_red, O_green, O_blue}), 0);
        check("async reset underrun", int'(O_underrun), 0);
        I_rd_active = 1'b0;
        tick();
        I_reset = 1'b1;
        write_line(7, 0, 256);
        check("post-reset full ready", int'(O_pix_ready), 0);
        pulse_line_end();
        check("post-reset underrun", int'(O_underrun), 0);
        read_line(7);

        check("scoreboard drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
